// File: rtl/pio_bidir_irq_if.sv
// Register-bus bundle for the bidirectional PIO block.
// The master drives the address, strobes and write data; the slave returns registered read data.
interface pio_bidir_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_bidir_irq.sv
// Bidirectional parallel I/O with per-pin direction, a synchronised input path,
// edge capture with write-1-to-clear, an interrupt mask and a registered level interrupt.
module pio_bidir_irq #(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_DIR   = 32'h0000_0000,
  parameter logic [31:0] RESET_OUT   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  pio_bidir_irq_if.slave    bus,
  inout  wire  [WIDTH-1:0]  bidir_port,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_CAPT   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  // Edge detection opens only once the sync chain and prev hold real pin samples.
  localparam logic [2:0] WARM_DONE   = 3'(SYNC_STAGES + 1);
  localparam logic [1:0] EDGE_SEL    = 2'(EDGE_TYPE);

  logic [WIDTH-1:0]                  dir_q,  dir_d;
  logic [WIDTH-1:0]                  out_q,  out_d;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q,  cap_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [2:0]                        warm_q, warm_d;
  logic [31:0]                       rdata_q, rdata_d;
  logic                              irq_q,  irq_d;

  logic [WIDTH-1:0] synced_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] wdata_s;
  logic             wr_en_s;

  assign synced_s     = sync_q[SYNC_STAGES-1];
  assign wr_en_s      = bus.chipselect & ~bus.write_n;
  assign wdata_s      = bus.writedata[WIDTH-1:0];
  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // Input synchroniser chain and one-cycle delayed copy of the synced value.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bidir_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = synced_s;
  end

  // Warm-up counter and edge vector, regardless of pin direction.
  always_comb begin
    edge_s = '0;
    warm_d = warm_q;
    if (warm_q == WARM_DONE) begin
      warm_d = warm_q;
      case (EDGE_SEL)
        2'd0:    edge_s = synced_s & ~prev_q;
        2'd1:    edge_s = ~synced_s & prev_q;
        default: edge_s = synced_s ^ prev_q;
      endcase
    end else begin
      warm_d = warm_q + 3'd1;
      edge_s = '0;
    end
  end

  // Register writes; a capture edge beats a same-cycle write-1-to-clear.
  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en_s) begin
      case (bus.address)
        ADDR_DATA:   out_d  = wdata_s;
        ADDR_DIR:    dir_d  = wdata_s;
        ADDR_MASK:   mask_d = wdata_s;
        ADDR_CAPT:   cap_d  = cap_q & ~wdata_s;
        ADDR_OUTSET: out_d  = out_q | wdata_s;
        ADDR_OUTCLR: out_d  = out_q & ~wdata_s;
        default:     dir_d  = dir_q;
      endcase
    end else begin
      cap_d = cap_q;
    end
    cap_d = cap_d | edge_s;
    irq_d = |(cap_q & mask_q);
  end

  // Read mux, loaded every cycle; upper bits above WIDTH stay zero.
  always_comb begin
    rdata_d = 32'h0000_0000;
    case (bus.address)
      ADDR_DATA: rdata_d[WIDTH-1:0] = synced_s;
      ADDR_DIR:  rdata_d[WIDTH-1:0] = dir_q;
      ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
      ADDR_CAPT: rdata_d[WIDTH-1:0] = cap_q;
      default:   rdata_d            = 32'h0000_0000;
    endcase
  end

  // State register; reset overrides bus writes and edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q   <= RESET_DIR[WIDTH-1:0];
      out_q   <= RESET_OUT[WIDTH-1:0];
      mask_q  <= '0;
      cap_q   <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      warm_q  <= 3'd0;
      rdata_q <= 32'h0000_0000;
      irq_q   <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      prev_q  <= prev_d;
      sync_q  <= sync_d;
      warm_q  <= warm_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Directed bench: rising-edge 32-pin instance, falling-edge 32-pin instance,
// and an 8-pin any-edge instance with non-zero reset direction/output values.
module tb_pio_bidir_irq;

  logic clk;
  logic rst0, rst1, rst2;
  logic irq0, irq1, irq2;
  wire  [31:0] pins0;
  wire  [31:0] pins1;
  wire  [7:0]  pins2;
  logic [31:0] drv0, oe0, drv1, oe1;
  logic [7:0]  drv2, oe2;

  logic [2:0]  tb_addr;
  logic [31:0] tb_wd;
  logic        tb_wn;
  logic [2:0]  tb_cs;

  int n_cmp;
  int n_err;

  pio_bidir_irq_if bus0 ();
  pio_bidir_irq_if bus1 ();
  pio_bidir_irq_if bus2 ();

  assign bus0.address = tb_addr;  assign bus0.writedata = tb_wd;
  assign bus0.write_n = tb_wn;    assign bus0.chipselect = tb_cs[0];
  assign bus1.address = tb_addr;  assign bus1.writedata = tb_wd;
  assign bus1.write_n = tb_wn;    assign bus1.chipselect = tb_cs[1];
  assign bus2.address = tb_addr;  assign bus2.writedata = tb_wd;
  assign bus2.write_n = tb_wn;    assign bus2.chipselect = tb_cs[2];

  for (genvar i = 0; i < 32; i++) begin : g_drv01
    assign pins0[i] = oe0[i] ? drv0[i] : 1'bz;
    assign pins1[i] = oe1[i] ? drv1[i] : 1'bz;
  end
  for (genvar i = 0; i < 8; i++) begin : g_drv2
    assign pins2[i] = oe2[i] ? drv2[i] : 1'bz;
  end

  pio_bidir_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(rst0), .bus(bus0), .bidir_port(pins0), .irq(irq0));

  pio_bidir_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset(rst1), .bus(bus1), .bidir_port(pins1), .irq(irq1));

  pio_bidir_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2),
                  .RESET_DIR(32'h0000_005A), .RESET_OUT(32'h0000_0033)) u2 (
    .clk(clk), .reset(rst2), .bus(bus2), .bidir_port(pins2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
    tb_addr = a;
    tb_wd   = d;
    tb_wn   = 1'b0;
    tb_cs   = 3'b001 << sel;
    tick();
    tb_wn   = 1'b1;
    tb_cs   = 3'b000;
  endtask

  task automatic rd(input logic [2:0] a);
    tb_addr = a;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tb_addr = 3'd0; tb_wd = 32'h0; tb_wn = 1'b1; tb_cs = 3'b000;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    oe0 = 32'hFFFF_FFFF; drv0 = 32'h3C5A_A5A5;
    oe1 = 32'hFFFF_FFFF; drv1 = 32'hFFFF_FFFF;
    oe2 = 8'hA5;         drv2 = 8'hA5;
    repeat (3) tick();

    chk("rst_rdata0", bus0.readdata, 32'h0);
    chk("rst_irq0", {31'h0, irq0}, 32'h0);
    chk("rst_rdata2", bus2.readdata, 32'h0);
    chk("rst_irq2", {31'h0, irq2}, 32'h0);
    chk("rst_pins2", {24'h0, pins2}, 32'h0000_00B7);

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (8) tick();

    // Pins held steady through reset release must not capture.
    rd(3'd3);
    chk("warm_cap0", bus0.readdata, 32'h0);
    chk("warm_cap1", bus1.readdata, 32'h0);
    chk("warm_cap2", bus2.readdata, 32'h0);

    // Lower half output, upper half input driven by the bench.
    wr(0, 3'd0, 32'hA5A5_A5A5);
    wr(0, 3'd1, 32'h0000_FFFF);
    oe0 = 32'hFFFF_0000;
    tick(); tick();
    chk("pins0_low", {16'h0, pins0[15:0]}, 32'h0000_A5A5);
    rd(3'd1);
    chk("dir0", bus0.readdata, 32'h0000_FFFF);
    rd(3'd0);
    chk("synced0", bus0.readdata, 32'h3C5A_A5A5);

    tb_addr = 3'd1; tb_wd = 32'h0; tb_wn = 1'b0; tb_cs = 3'b000;
    tick();
    tb_wn = 1'b1;
    rd(3'd1);
    chk("nocs_write", bus0.readdata, 32'h0000_FFFF);
    wr(0, 3'd6, 32'hFFFF_FFFF);
    rd(3'd6);
    chk("rd_unmapped", bus0.readdata, 32'h0);
    rd(3'd4);
    chk("rd_outset", bus0.readdata, 32'h0);

    wr(0, 3'd0, 32'h0000_00F0);
    chk("out_f0", {16'h0, pins0[15:0]}, 32'h0000_00F0);
    wr(0, 3'd4, 32'h0000_000F);
    chk("outset", {16'h0, pins0[15:0]}, 32'h0000_00FF);
    wr(0, 3'd5, 32'h0000_003C);
    chk("outclear", {16'h0, pins0[15:0]}, 32'h0000_00C3);

    // Hand the pins back to the bench, then clear stale captures.
    drv0 = 32'h3C5A_00C3;
    oe0  = 32'hFFFF_FFFF;
    wr(0, 3'd1, 32'h0);
    repeat (4) tick();
    wr(0, 3'd3, 32'hFFFF_FFFF);
    rd(3'd3);
    chk("w1c_all", bus0.readdata, 32'h0);
    wr(0, 3'd2, 32'h0000_0001);
    rd(3'd2);
    chk("mask0", bus0.readdata, 32'h0000_0001);
    chk("irq0_idle", {31'h0, irq0}, 32'h0);

    drv0[0] = 1'b0;
    repeat (4) tick();
    rd(3'd3);
    chk("fall_ignored", bus0.readdata, 32'h0);

    // Rising pin0 sampled at edge k: capture after k+2, irq after k+3.
    drv0[0] = 1'b1;
    tb_addr = 3'd3;
    tick();
    tick();
    chk("irq_k1", {31'h0, irq0}, 32'h0);
    tick();
    chk("cap_k1", bus0.readdata, 32'h0);
    chk("irq_k2", {31'h0, irq0}, 32'h0);
    tick();
    chk("cap_k2", bus0.readdata, 32'h0000_0001);
    chk("irq_k3", {31'h0, irq0}, 32'h1);

    wr(0, 3'd3, 32'h0000_0001);
    chk("irq_hold", {31'h0, irq0}, 32'h1);
    tick();
    chk("irq_clr", {31'h0, irq0}, 32'h0);
    chk("cap_clr", bus0.readdata, 32'h0);

    // W1C of bit 3 lands on the same edge that captures bit 3.
    drv0[3] = 1'b1;
    tick();
    tick();
    wr(0, 3'd3, 32'h0000_0008);
    rd(3'd3);
    chk("set_wins", bus0.readdata, 32'h0000_0008);
    chk("irq_masked", {31'h0, irq0}, 32'h0);
    wr(0, 3'd3, 32'h0000_0008);
    rd(3'd3);
    chk("w1c_bit3", bus0.readdata, 32'h0);

    drv1[5] = 1'b0;
    repeat (4) tick();
    rd(3'd3);
    chk("fall_cap1", bus1.readdata, 32'h0000_0020);
    rd(3'd0);
    chk("synced1", bus1.readdata, 32'hFFFF_FFDF);

    rd(3'd0);
    chk("w8_synced", bus2.readdata, 32'h0000_00B7);
    rd(3'd1);
    chk("w8_dir_rst", bus2.readdata, 32'h0000_005A);
    drv2 = 8'hB7;
    oe2  = 8'hFF;
    wr(2, 3'd1, 32'h0);
    wr(2, 3'd2, 32'h0000_00FF);
    tick();
    chk("w8_irq_idle", {31'h0, irq2}, 32'h0);
    drv2[0] = 1'b0;
    repeat (4) tick();
    chk("w8_irq_set", {31'h0, irq2}, 32'h1);
    rd(3'd3);
    chk("w8_cap", bus2.readdata, 32'h0000_0001);

    // Reset wins over a concurrent write.
    rst2 = 1'b1;
    wr(2, 3'd1, 32'h0000_00FF);
    rst2 = 1'b0;
    chk("w8_irq_rst", {31'h0, irq2}, 32'h0);
    chk("w8_rdata_rst", bus2.readdata, 32'h0);
    rd(3'd1);
    chk("w8_dir_back", bus2.readdata, 32'h0000_005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
